// File: rtl/ieee_adder_normalize_pkg.sv
// ieee_adder_normalize_pkg: shared widths, number/exponent/significand types, FSM state encoding and the all-ones exponent
package ieee_adder_normalize_pkg;
  localparam int EXP_WIDTH = 8;
  localparam int FRAC_WIDTH = 23;
  localparam int GUARD_BITS = 3;
  localparam int SIG_WIDTH = FRAC_WIDTH + GUARD_BITS + 2;
  localparam int NUM_WIDTH = 1 + EXP_WIDTH + FRAC_WIDTH;
  localparam int HIDDEN = FRAC_WIDTH + GUARD_BITS;
  typedef logic [NUM_WIDTH-1:0] number_t;
  typedef logic [EXP_WIDTH-1:0] expo_t;
  typedef logic [SIG_WIDTH-1:0] signif_t;
  typedef logic [FRAC_WIDTH-1:0] frac_t;
  localparam expo_t EXP_ONES = '1;
  typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;
endpackage

// File: rtl/ieee_adder_normalize_if.sv
// ieee_adder_normalize_if: raw-sum input handshake (valid/ready, sign, exponent, significand) and packed-result output handshake (valid/ready, number, overflow, inexact)
interface ieee_adder_normalize_if;
  import ieee_adder_normalize_pkg::*;
  logic in_valid;
  logic in_ready;
  logic in_sign;
  expo_t in_exponent;
  signif_t in_significand;
  logic out_valid;
  logic out_ready;
  number_t out_number;
  logic out_overflow;
  logic out_inexact;
  modport master (
    output in_valid, in_sign, in_exponent, in_significand, out_ready,
    input in_ready, out_valid, out_number, out_overflow, out_inexact
  );
  modport slave (
    input in_valid, in_sign, in_exponent, in_significand, out_ready,
    output in_ready, out_valid, out_number, out_overflow, out_inexact
  );
endinterface

// File: rtl/ieee_adder_normalize_round.sv
// ieee_adder_round: combinational rounding of a normalized 27-bit significand (hidden, fraction, guard) and exponent into fraction/exponent/overflow/inexact; IEEE_ADDER_ROUND_NEAREST_EN selects round-to-nearest-even, else truncate
module ieee_adder_round
  import ieee_adder_normalize_pkg::*;
(
  input  logic [SIG_WIDTH-2:0] significand,
  input  expo_t                exponent,
  output frac_t                fraction,
  output expo_t                exponent_out,
  output logic                 overflow,
  output logic                 inexact
);
  logic inc;
  logic [FRAC_WIDTH:0] sum;
  expo_t base;
`ifdef IEEE_ADDER_ROUND_NEAREST_EN
  assign inc = significand[GUARD_BITS-1] & (significand[GUARD_BITS-2] | significand[0] | significand[GUARD_BITS]);
`else
  assign inc = 1'b0;
`endif
  assign sum = {1'b0, significand[HIDDEN-1:GUARD_BITS]} + {{FRAC_WIDTH{1'b0}}, inc};
  assign base = significand[HIDDEN] ? exponent : '0;
  assign exponent_out = base + {{(EXP_WIDTH-1){1'b0}}, sum[FRAC_WIDTH]};
  assign fraction = sum[FRAC_WIDTH-1:0];
  assign overflow = exponent_out == EXP_ONES;
  assign inexact = |significand[GUARD_BITS-1:0];
endmodule

// File: rtl/ieee_adder_normalize.sv
// ieee_adder_normalize: multi-cycle normalize/round FSM (clk, reset, bus slave) turning a raw adder sum into an IEEE single; rounding mode via IEEE_ADDER_ROUND_NEAREST_EN
module ieee_adder_normalize
  import ieee_adder_normalize_pkg::*;
(
  input logic clk,
  input logic reset,
  ieee_adder_normalize_if.slave bus
);
  state_t state;
  logic sign;
  logic [SIG_WIDTH-2:0] sig;
  expo_t exp_w;
  expo_t eff;
  expo_t einc;
  logic [SIG_WIDTH-2:0] rsh;
  frac_t r_frac;
  expo_t r_exp;
  logic r_ovf;
  logic r_inx;
  assign eff = bus.in_exponent == '0 ? expo_t'(1) : bus.in_exponent;
  assign einc = eff + expo_t'(1);
  assign rsh = bus.in_significand[SIG_WIDTH-1:1] | {{(SIG_WIDTH-2){1'b0}}, bus.in_significand[0]};
  assign bus.in_ready = state == IDLE && !reset;
  ieee_adder_round u_round (
    .significand(sig),
    .exponent(exp_w),
    .fraction(r_frac),
    .exponent_out(r_exp),
    .overflow(r_ovf),
    .inexact(r_inx)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      bus.out_valid <= 1'b0;
      bus.out_number <= '0;
      bus.out_overflow <= 1'b0;
      bus.out_inexact <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          sign <= bus.in_sign;
          sig <= bus.in_significand[SIG_WIDTH-2:0];
          exp_w <= eff;
          bus.out_overflow <= 1'b0;
          bus.out_inexact <= 1'b0;
          state <= SHIFT;
          if (bus.in_exponent == EXP_ONES) begin
            bus.out_number <= {bus.in_sign, EXP_ONES, bus.in_significand[HIDDEN-1:GUARD_BITS]};
            bus.out_valid <= 1'b1;
            state <= DONE;
          end else if (bus.in_significand == '0) begin
            bus.out_number <= {bus.in_sign, {(NUM_WIDTH-1){1'b0}}};
            bus.out_valid <= 1'b1;
            state <= DONE;
          end else if (bus.in_significand[SIG_WIDTH-1]) begin
            sig <= rsh;
            exp_w <= einc;
            if (einc == EXP_ONES) begin
              bus.out_number <= {bus.in_sign, EXP_ONES, {FRAC_WIDTH{1'b0}}};
              bus.out_overflow <= 1'b1;
              bus.out_inexact <= 1'b1;
              bus.out_valid <= 1'b1;
              state <= DONE;
            end
          end
        end
        SHIFT: if (sig[HIDDEN] || exp_w == expo_t'(1)) begin
          state <= ROUND;
        end else begin
          sig <= sig << 1;
          exp_w <= exp_w - expo_t'(1);
        end
        ROUND: begin
          bus.out_number <= r_ovf ? {sign, EXP_ONES, {FRAC_WIDTH{1'b0}}} : {sign, r_exp, r_frac};
          bus.out_overflow <= r_ovf;
          bus.out_inexact <= r_inx;
          bus.out_valid <= 1'b1;
          state <= DONE;
        end
        DONE: if (bus.out_ready) begin
          bus.out_valid <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ieee_adder_normalize.sv
// tb_ieee_adder_normalize: directed vector table plus backpressure and mid-shift reset sequences for ieee_adder_normalize
module tb_ieee_adder_normalize;
  import ieee_adder_normalize_pkg::*;
`ifdef IEEE_ADDER_ROUND_NEAREST_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif
  typedef struct {
    logic sign;
    logic [7:0] exp;
    logic [27:0] sig;
    logic [31:0] num;
    logic ovf;
    logic inx;
    int lat;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int failed = 0;
  vec_t vecs[13];
  ieee_adder_normalize_if bus();
  ieee_adder_normalize dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic s, input logic [7:0] e, input logic [27:0] g);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_sign = s;
    bus.in_exponent = e;
    bus.in_significand = g;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    chk("accept_wait", 32'(n < 50), 32'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask
  task automatic wait_out(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      tick();
      lat++;
    end
  endtask
  initial begin
    int lat;
    logic [31:0] held;
    vecs[0]  = '{1'b0, 8'd127, 28'h8000000, 32'h40000000, 1'b0, 1'b0, 3};
    vecs[1]  = '{1'b0, 8'd127, 28'h0000008, 32'h34000000, 1'b0, 1'b0, 26};
    vecs[2]  = '{1'b1, 8'd5,   28'h0000000, 32'h80000000, 1'b0, 1'b0, 1};
    vecs[3]  = '{1'b0, 8'd254, 28'h8000000, 32'h7F800000, 1'b1, 1'b1, 1};
    vecs[4]  = '{1'b0, 8'd127, 28'h4000004, 32'h3F800000, 1'b0, 1'b1, 3};
    vecs[5]  = '{1'b0, 8'd127, 28'h400000C, RNE ? 32'h3F800002 : 32'h3F800001, 1'b0, 1'b1, 3};
    vecs[6]  = '{1'b0, 8'd3,   28'h0200000, 32'h00100000, 1'b0, 1'b0, 5};
    vecs[7]  = '{1'b1, 8'd255, 28'h0400008, 32'hFF880001, 1'b0, 1'b0, 1};
    vecs[8]  = '{1'b0, 8'd127, 28'hC000001, 32'h40400000, 1'b0, 1'b1, 3};
    vecs[9]  = '{1'b0, 8'd127, 28'h7FFFFFC, RNE ? 32'h40000000 : 32'h3FFFFFFF, 1'b0, 1'b1, 3};
    vecs[10] = '{1'b0, 8'd254, 28'h7FFFFFF, RNE ? 32'h7F800000 : 32'h7F7FFFFF, RNE, 1'b1, 3};
    vecs[11] = '{1'b0, 8'd0,   28'h0000010, 32'h00000002, 1'b0, 1'b0, 3};
    vecs[12] = '{1'b0, 8'd1,   28'h3FFFFFC, RNE ? 32'h00800000 : 32'h007FFFFF, 1'b0, 1'b1, 3};
    bus.in_valid = 1'b0;
    bus.in_sign = 1'b0;
    bus.in_exponent = '0;
    bus.in_significand = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_number", bus.out_number, 32'h0);
    chk("rst_flags", {30'd0, bus.out_overflow, bus.out_inexact}, 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].sign, vecs[i].exp, vecs[i].sig);
      wait_out(lat);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("v%0d_number", i), bus.out_number, vecs[i].num);
      chk($sformatf("v%0d_overflow", i), 32'(bus.out_overflow), 32'(vecs[i].ovf));
      chk($sformatf("v%0d_inexact", i), 32'(bus.out_inexact), 32'(vecs[i].inx));
      chk($sformatf("v%0d_busy_in_ready", i), 32'(bus.in_ready), 32'd0);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk($sformatf("v%0d_consumed", i), {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
    end
    drive(1'b0, 8'd127, 28'h8000000);
    wait_out(lat);
    held = bus.out_number;
    chk("bp_first", held, 32'h40000000);
    bus.in_valid = 1'b1;
    bus.in_sign = 1'b1;
    bus.in_exponent = 8'd9;
    bus.in_significand = 28'h0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("bp_hold%0d_number", c), bus.out_number, held);
      chk($sformatf("bp_hold%0d_valid_ready", c), {30'd0, bus.out_valid, bus.in_ready}, 32'd2);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("bp_handshake_no_accept", {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("bp_next_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_next_number", bus.out_number, 32'h80000000);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    drive(1'b0, 8'd127, 28'h0000008);
    for (int c = 0; c < 5; c++) tick();
    chk("mid_shift_busy", {30'd0, bus.out_valid, bus.in_ready}, 32'd0);
    reset = 1'b1;
    tick();
    chk("mid_rst_valid_ready", {30'd0, bus.out_valid, bus.in_ready}, 32'd0);
    reset = 1'b0;
    tick();
    chk("after_rst_valid_ready", {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
    for (int c = 0; c < 30; c++) tick();
    chk("after_rst_no_stale", 32'(bus.out_valid), 32'd0);
    drive(1'b0, 8'd127, 28'h4000004);
    wait_out(lat);
    chk("recover_latency", 32'(lat), 32'd3);
    chk("recover_number", bus.out_number, 32'h3F800000);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
